// File: rtl/rf_seq_ctrl.sv
// Sequencer for a 4-register datapath: fetches 10-bit instructions, steers the register set and ALU,
// and runs valid/ready handshakes with the instruction source and the input/output devices.
module rf_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [4:0] pc,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] RA,
  output logic [1:0] RB,
  output logic       RE,
  output logic [1:0] WR,
  output logic       InE,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       err
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_WB       = 3'd3,
    S_IN_WAIT  = 3'd4,
    S_OUT_WAIT = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] ir, ir_nxt;
  logic [4:0] pc_nxt;
  logic       err_nxt;
  logic       alu_phase;

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = pc;
    err_nxt   = err;
    case (state)
      S_FETCH: begin
        if (instr_valid) begin
          ir_nxt    = instr;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir[9:6])
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: state_nxt = S_EXEC;
          4'd7:  state_nxt = S_IN_WAIT;
          4'd8:  state_nxt = S_OUT_WAIT;
          4'd9: begin
            pc_nxt    = ir[4:0];
            state_nxt = S_FETCH;
          end
          4'd15: state_nxt = S_HALT;
          4'd0: begin
            pc_nxt    = pc + 5'd1;
            state_nxt = S_FETCH;
          end
          default: begin
            err_nxt   = 1'b1;
            pc_nxt    = pc + 5'd1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        // R2 is only loadable from the input device, so an ALU write to it is refused.
        if (ir[5:4] == 2'b10) err_nxt = 1'b1;
        pc_nxt    = pc + 5'd1;
        state_nxt = S_FETCH;
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          pc_nxt    = pc + 5'd1;
          state_nxt = S_FETCH;
        end
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          pc_nxt    = pc + 5'd1;
          state_nxt = S_FETCH;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign alu_phase = (state_nxt == S_EXEC) || (state_nxt == S_WB);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      ir          <= '0;
      pc          <= '0;
      err         <= 1'b0;
      instr_ready <= 1'b1;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      RA          <= '0;
      RB          <= '0;
      RE          <= 1'b0;
      WR          <= '0;
      alu_op      <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      ir          <= ir_nxt;
      pc          <= pc_nxt;
      err         <= err_nxt;
      instr_ready <= (state_nxt == S_FETCH);
      in_ready    <= (state_nxt == S_IN_WAIT);
      out_valid   <= (state_nxt == S_OUT_WAIT);
      RA          <= alu_phase ? ir_nxt[3:2] : 2'b00;
      RB          <= alu_phase ? ir_nxt[1:0] : 2'b00;
      alu_op      <= alu_phase ? ir_nxt[8:6] : 3'b000;
      WR          <= (state_nxt == S_WB) ? ir_nxt[5:4] : 2'b00;
      RE          <= (state_nxt == S_WB) && (ir_nxt[5:4] != 2'b10);
      halted      <= (state_nxt == S_HALT);
    end
  end

  // The load strobe must coincide with the device's valid, so it is the handshake itself.
  assign InE = in_ready & in_valid & ~reset;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl: directed instruction sequences, an instruction-level reference model
// compared on every cycle, and literal expectations at the points the sequences are meant to hit.
module tb_rf_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       instr_ready, in_ready, out_valid, RE, InE, halted, err;
  logic [4:0] pc;
  logic [1:0] RA, RB, WR;
  logic [2:0] alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_seq_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .RA(RA), .RB(RB), .RE(RE),
    .WR(WR), .InE(InE), .alu_op(alu_op), .halted(halted), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction becomes a list of cycle-steps; a step retires when its
  // handshake (if any) completes, and its architectural side effects apply then.
  localparam int K_DEC = 0, K_EXEC = 1, K_WB = 2, K_IN = 3, K_OUT = 4;
  typedef struct {
    int         kind;
    logic [1:0] ra, rb, rd;
    logic [2:0] op;
    int         pc_act;
    logic [4:0] tgt;
    bit         set_err;
    bit         to_halt;
  } step_t;

  step_t q[$];
  int    m_pc = 0;
  bit    m_err = 0, m_halt = 0, model_ok = 0;
  step_t cur;
  bit    done;

  function automatic step_t mk(input int kind, input int pa, input bit se, input bit th,
                               input logic [9:0] w);
    step_t s;
    s.kind = kind; s.op = w[8:6]; s.rd = w[5:4]; s.ra = w[3:2]; s.rb = w[1:0];
    s.tgt = w[4:0]; s.pc_act = pa; s.set_err = se; s.to_halt = th;
    return s;
  endfunction

  task automatic push_instr(input logic [9:0] w);
    int op;
    op = int'(w[9:6]);
    if (op >= 1 && op <= 6) begin
      q.push_back(mk(K_DEC, 0, 0, 0, w));
      q.push_back(mk(K_EXEC, 0, 0, 0, w));
      q.push_back(mk(K_WB, 1, (w[5:4] == 2'b10), 0, w));
    end else if (op == 7) begin
      q.push_back(mk(K_DEC, 0, 0, 0, w));
      q.push_back(mk(K_IN, 1, 0, 0, w));
    end else if (op == 8) begin
      q.push_back(mk(K_DEC, 0, 0, 0, w));
      q.push_back(mk(K_OUT, 1, 0, 0, w));
    end else if (op == 9)  q.push_back(mk(K_DEC, 2, 0, 0, w));
    else if (op == 15)     q.push_back(mk(K_DEC, 0, 0, 1, w));
    else if (op == 0)      q.push_back(mk(K_DEC, 1, 0, 0, w));
    else                   q.push_back(mk(K_DEC, 1, 1, 0, w));
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_pc = 0; m_err = 0; m_halt = 0; model_ok = 1;
    end else if (model_ok && !m_halt) begin
      if (q.size() == 0) begin
        if (instr_valid) push_instr(instr);
      end else begin
        cur  = q[0];
        done = (cur.kind == K_IN) ? in_valid : (cur.kind == K_OUT) ? out_ready : 1'b1;
        if (done) begin
          void'(q.pop_front());
          if (cur.set_err) m_err = 1;
          if (cur.pc_act == 1) m_pc = (m_pc + 1) % 32;
          else if (cur.pc_act == 2) m_pc = int'(cur.tgt);
          if (cur.to_halt) m_halt = 1;
        end
      end
    end
  end

  logic [20:0] e_vec, a_vec;
  always @(negedge clk) begin
    if (model_ok) begin
      logic e_ir, e_inr, e_ov, e_re, e_ine, e_h;
      logic [1:0] e_ra, e_rb, e_wr;
      logic [2:0] e_op;
      e_ir = 0; e_inr = 0; e_ov = 0; e_re = 0; e_ine = 0; e_h = 0;
      e_ra = 0; e_rb = 0; e_wr = 0; e_op = 0;
      if (m_halt) e_h = 1;
      else if (q.size() == 0) e_ir = 1;
      else begin
        case (q[0].kind)
          K_EXEC: begin e_ra = q[0].ra; e_rb = q[0].rb; e_op = q[0].op; end
          K_WB: begin
            e_ra = q[0].ra; e_rb = q[0].rb; e_op = q[0].op;
            e_wr = q[0].rd; e_re = (q[0].rd != 2'b10);
          end
          K_IN:    begin e_inr = 1; e_ine = in_valid && !reset; end
          K_OUT:   e_ov = 1;
          default: ;
        endcase
      end
      e_vec = {e_ir, 5'(m_pc), e_inr, e_ov, e_ra, e_rb, e_re, e_wr, e_ine, e_op, e_h, m_err};
      a_vec = {instr_ready, pc, in_ready, out_valid, RA, RB, RE, WR, InE, alu_op, halted, err};
      chk("cycle_outputs", 32'(a_vec), 32'(e_vec));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [9:0] w);
    instr = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cr, ce;
    reset = 1'b1;
    step(); step();
    chk("rst_instr_ready", 32'(instr_ready), 1);
    chk("rst_other_outs", 32'({pc, in_ready, out_valid, RA, RB, RE, WR, InE, alu_op, halted, err}), 0);
    reset = 1'b0;

    // ADD R1 <= R0 op R3, instr_valid held through the instruction.
    instr = 10'b0001_01_00_11; instr_valid = 1'b1;
    step();
    chk("add_c1_instr_ready", 32'(instr_ready), 0);
    step();
    chk("add_c2_ra", 32'(RA), 0);
    chk("add_c2_rb", 32'(RB), 3);
    chk("add_c2_alu_op", 32'(alu_op), 1);
    chk("add_c2_re", 32'(RE), 0);
    step();
    chk("add_c3_re", 32'(RE), 1);
    chk("add_c3_wr", 32'(WR), 1);
    chk("add_c3_pc", 32'(pc), 0);
    step();
    chk("add_c4_fetch", 32'(instr_ready), 1);
    chk("add_c4_pc", 32'(pc), 1);
    instr_valid = 1'b0;

    // IN with data arriving 5 cycles after DECODE.
    issue(10'b0111_00_00_00);
    step();
    cr = 0; ce = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k == 5);
      #1;
      if (in_ready) cr++;
      if (InE) ce++;
      step();
    end
    in_valid = 1'b0;
    chk("in_ready_cycles", 32'(cr), 6);
    chk("ine_pulses", 32'(ce), 1);
    chk("in_pc", 32'(pc), 2);

    // OUT with the consumer stalling 3 cycles.
    issue(10'b1000_00_00_00);
    step();
    cr = 0;
    for (int k = 0; k < 8; k++) begin
      out_ready = (k == 3);
      #1;
      if (out_valid) cr++;
      step();
    end
    out_ready = 1'b0;
    chk("out_valid_cycles", 32'(cr), 4);
    chk("out_pc", 32'(pc), 3);

    // ALU write targeting R2 is refused and flags err.
    issue(10'b0010_10_01_01);
    step(); step();
    chk("rd2_wb_re", 32'(RE), 0);
    chk("rd2_wb_err_before", 32'(err), 0);
    step();
    chk("rd2_err_set", 32'(err), 1);
    chk("rd2_pc", 32'(pc), 4);
    issue(10'b0000_00_00_00);
    step();
    chk("err_sticky_after_nop", 32'(err), 1);
    chk("nop_pc", 32'(pc), 5);

    // Reset clears err; an undefined opcode sets it again.
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_clears_err", 32'(err), 0);
    issue(10'b1010_00_00_00);
    step();
    chk("illegal_err", 32'(err), 1);
    chk("illegal_pc", 32'(pc), 1);

    issue(10'b1001_0_11010);
    step();
    chk("jmp_pc", 32'(pc), 26);

    // Reset arriving in WB aborts the write.
    issue(10'b0001_01_00_11);
    step(); step();
    chk("wb_re_before_reset", 32'(RE), 1);
    reset = 1'b1;
    step();
    chk("reset_wb_re", 32'(RE), 0);
    chk("reset_wb_pc", 32'(pc), 0);
    chk("reset_wb_fetch", 32'(instr_ready), 1);
    reset = 1'b0;

    issue(10'b1001_0_11111);
    step();
    chk("jmp31_pc", 32'(pc), 31);
    issue(10'b0000_00_00_00);
    step();
    chk("pc_wrap", 32'(pc), 0);

    issue(10'b0000_00_00_00);
    step();
    issue(10'b1111_00_00_00);
    step();
    chk("halt_flag", 32'(halted), 1);
    chk("halt_instr_ready", 32'(instr_ready), 0);
    instr = 10'b0000_00_00_00; instr_valid = 1'b1;
    repeat (5) step();
    chk("halt_holds", 32'(halted), 1);
    chk("halt_pc_frozen", 32'(pc), 1);
    chk("halt_ignores_instr", 32'(instr_ready), 0);
    instr_valid = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
